// File: rtl/sym_err_pkg.sv
// sym_err_pkg: shared state encoding and saturating counter helper for sym_err_meter
package sym_err_pkg;

    typedef enum logic [1:0] {IDLE, ALIGN, SYNC, MEASURE} state_t;

    localparam int MAX_CNT_WID = 32;
    typedef logic [MAX_CNT_WID-1:0] cnt_t;

    function automatic cnt_t sat_inc(input cnt_t v, input cnt_t lim, input logic inc);
        return (inc && v != lim) ? v + cnt_t'(1) : v;
    endfunction

endpackage

// File: rtl/sym_delay_line.sv
// sym_delay_line: DEPTH-stage enabled shift register aligning reference symbols with slicer output
module sym_delay_line #(
    parameter int DEPTH = 3,
    parameter int WID   = 2
) (
    input  logic           sys_clk,
    input  logic           reset,
    input  logic           en,
    input  logic [WID-1:0] din,
    output logic [WID-1:0] dout
);

    logic [WID-1:0] sr [DEPTH];

    // shift one stage per symbol strobe
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            sr <= '{default: '0};
        end else if (en) begin
            sr[0] <= din;
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
    end

    assign dout = sr[DEPTH-1];

endmodule

// File: rtl/sym_err_meter.sv
// sym_err_meter: armed single-shot symbol error meter over one clr_acc-framed window
// Optional macro SYM_ERR_FIRST_IDX_EN adds first_err_idx (1-based index of first mismatch per channel).
module sym_err_meter
    import sym_err_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int SYM_WID = 2,
    parameter int DELAY   = 3,
    parameter int CNT_WID = 24
) (
    input  logic                      sys_clk,
    input  logic                      reset,
    input  logic                      sym_clk_en,
    input  logic                      start,
    input  logic                      clr_acc,
    input  logic [NUM_CH*SYM_WID-1:0] ref_sym,
    input  logic [NUM_CH*SYM_WID-1:0] slice,
    output logic                      busy,
    output logic                      result_valid,
    output logic [CNT_WID-1:0]        sym_cnt,
    output logic [NUM_CH*CNT_WID-1:0] err_cnt,
    output logic [NUM_CH-1:0]         err_sat,
    output logic [NUM_CH-1:0]         sym_cor,
    output logic [NUM_CH-1:0]         sym_err
`ifdef SYM_ERR_FIRST_IDX_EN
    ,
    output logic [NUM_CH*CNT_WID-1:0] first_err_idx
`endif
);

    localparam logic [CNT_WID-1:0] CMAX = '1;
    localparam int AW = $clog2(DELAY + 1);

    state_t                    state, state_nx;
    logic [AW-1:0]             align_cnt;
    logic [NUM_CH-1:0]         equal;
    logic [CNT_WID-1:0]        w_sym, w_sym_nx;
    logic [NUM_CH*CNT_WID-1:0] w_err, w_err_nx;
    logic [NUM_CH-1:0]         w_sat, w_sat_nx;
`ifdef SYM_ERR_FIRST_IDX_EN
    logic [NUM_CH*CNT_WID-1:0] w_first, w_first_nx;
`endif

    logic win_edge;
    assign win_edge = sym_clk_en & clr_acc;
    assign busy     = (state != IDLE);
    assign w_sym_nx = CNT_WID'(sat_inc(cnt_t'(w_sym), cnt_t'(CMAX), 1'b1));

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [SYM_WID-1:0] dl_out;
        logic [CNT_WID-1:0] e;
        sym_delay_line #(.DEPTH(DELAY), .WID(SYM_WID)) u_dl (
            .sys_clk (sys_clk),
            .reset   (reset),
            .en      (sym_clk_en),
            .din     (ref_sym[c*SYM_WID +: SYM_WID]),
            .dout    (dl_out)
        );
        assign e           = w_err[c*CNT_WID +: CNT_WID];
        assign equal[c]    = (dl_out == slice[c*SYM_WID +: SYM_WID]);
        assign w_err_nx[c*CNT_WID +: CNT_WID] = CNT_WID'(sat_inc(cnt_t'(e), cnt_t'(CMAX), ~equal[c]));
        assign w_sat_nx[c] = w_sat[c] | (~equal[c] & (e == CMAX));
`ifdef SYM_ERR_FIRST_IDX_EN
        assign w_first_nx[c*CNT_WID +: CNT_WID] =
            (w_first[c*CNT_WID +: CNT_WID] == '0 && !equal[c]) ? w_sym_nx : w_first[c*CNT_WID +: CNT_WID];
`endif
    end

    // next-state: arm, flush delay line, wait for window open, measure until window close
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? ALIGN : IDLE;
            ALIGN:   state_nx = (sym_clk_en && align_cnt == AW'(DELAY - 1)) ? SYNC : ALIGN;
            SYNC:    state_nx = win_edge ? MEASURE : SYNC;
            MEASURE: state_nx = win_edge ? IDLE : MEASURE;
        endcase
    end

    // per-symbol match indicators, independent of the measurement state
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            sym_cor <= '0;
            sym_err <= '0;
        end else if (sym_clk_en) begin
            sym_cor <= equal;
            sym_err <= ~equal;
        end
    end

    // state register, working counters and latched results
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            align_cnt    <= '0;
            w_sym        <= '0;
            w_err        <= '0;
            w_sat        <= '0;
            sym_cnt      <= '0;
            err_cnt      <= '0;
            err_sat      <= '0;
            result_valid <= 1'b0;
`ifdef SYM_ERR_FIRST_IDX_EN
            w_first       <= '0;
            first_err_idx <= '0;
`endif
        end else begin
            state        <= state_nx;
            result_valid <= 1'b0;
            case (state)
                IDLE:  align_cnt <= '0;
                ALIGN: if (sym_clk_en) align_cnt <= align_cnt + 1'b1;
                SYNC: if (win_edge) begin
                    w_sym <= '0;
                    w_err <= '0;
                    w_sat <= '0;
`ifdef SYM_ERR_FIRST_IDX_EN
                    w_first <= '0;
`endif
                end
                MEASURE: if (sym_clk_en) begin
                    w_sym <= w_sym_nx;
                    w_err <= w_err_nx;
                    w_sat <= w_sat_nx;
`ifdef SYM_ERR_FIRST_IDX_EN
                    w_first <= w_first_nx;
                    if (clr_acc) first_err_idx <= w_first_nx;
`endif
                    if (clr_acc) begin
                        sym_cnt      <= w_sym_nx;
                        err_cnt      <= w_err_nx;
                        err_sat      <= w_sat_nx;
                        result_valid <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sym_err_meter.sv
// tb_sym_err_meter: directed scoreboard bench for sym_err_meter (CNT_WID=8 and CNT_WID=4 instances)
module tb_sym_err_meter;

    typedef struct packed {
        logic [31:0] sym, e0, e1, sat, f0, f1;
    } exp_t;

    logic        sys_clk, reset, sym_clk_en, start, clr_acc;
    logic [3:0]  ref_sym, slice;
    logic        busy8, rv8, busy4, rv4;
    logic [7:0]  sym_cnt8;
    logic [15:0] err_cnt8;
    logic [3:0]  sym_cnt4;
    logic [7:0]  err_cnt4;
    logic [1:0]  err_sat8, sym_cor8, sym_err8, err_sat4, sym_cor4, sym_err4;
`ifdef SYM_ERR_FIRST_IDX_EN
    logic [15:0] first8;
    logic [7:0]  first4;
`endif

    logic [3:0] hist [3];
    exp_t       q8 [$];
    exp_t       q4 [$];
    int         checks, errors, rv_cnt, err1_pulses;

    sym_err_meter #(.NUM_CH(2), .SYM_WID(2), .DELAY(3), .CNT_WID(8)) u_dut (
        .sys_clk(sys_clk), .reset(reset), .sym_clk_en(sym_clk_en), .start(start), .clr_acc(clr_acc),
        .ref_sym(ref_sym), .slice(slice), .busy(busy8), .result_valid(rv8), .sym_cnt(sym_cnt8),
        .err_cnt(err_cnt8), .err_sat(err_sat8), .sym_cor(sym_cor8), .sym_err(sym_err8)
`ifdef SYM_ERR_FIRST_IDX_EN
        , .first_err_idx(first8)
`endif
    );

    sym_err_meter #(.NUM_CH(2), .SYM_WID(2), .DELAY(3), .CNT_WID(4)) u_dut4 (
        .sys_clk(sys_clk), .reset(reset), .sym_clk_en(sym_clk_en), .start(start), .clr_acc(clr_acc),
        .ref_sym(ref_sym), .slice(slice), .busy(busy4), .result_valid(rv4), .sym_cnt(sym_cnt4),
        .err_cnt(err_cnt4), .err_sat(err_sat4), .sym_cor(sym_cor4), .sym_err(sym_err4)
`ifdef SYM_ERR_FIRST_IDX_EN
        , .first_err_idx(first4)
`endif
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_res8();
        exp_t e;
        chk("q8_pending", 32'(q8.size() != 0), 1);
        if (q8.size() != 0) begin
            e = q8.pop_front();
            chk("sym_cnt8", 32'(sym_cnt8), e.sym);
            chk("err_cnt8_ch0", 32'(err_cnt8[7:0]), e.e0);
            chk("err_cnt8_ch1", 32'(err_cnt8[15:8]), e.e1);
            chk("err_sat8", 32'(err_sat8), e.sat);
`ifdef SYM_ERR_FIRST_IDX_EN
            chk("first8_ch0", 32'(first8[7:0]), e.f0);
            chk("first8_ch1", 32'(first8[15:8]), e.f1);
`endif
        end
    endtask

    task automatic check_res4();
        exp_t e;
        chk("q4_pending", 32'(q4.size() != 0), 1);
        if (q4.size() != 0) begin
            e = q4.pop_front();
            chk("sym_cnt4", 32'(sym_cnt4), e.sym);
            chk("err_cnt4_ch0", 32'(err_cnt4[3:0]), e.e0);
            chk("err_cnt4_ch1", 32'(err_cnt4[7:4]), e.e1);
            chk("err_sat4", 32'(err_sat4), e.sat);
`ifdef SYM_ERR_FIRST_IDX_EN
            chk("first4_ch0", 32'(first4[3:0]), e.f0);
            chk("first4_ch1", 32'(first4[7:4]), e.f1);
`endif
        end
    endtask

    // one sys_clk cycle; slice follows ref_sym three strobes back, optionally inverted per channel
    task automatic step(input logic en, input logic clr, input logic st, input logic [1:0] inv);
        logic [3:0] r;
        r = 4'($urandom);
        sym_clk_en = en;
        clr_acc    = clr;
        start      = st;
        if (en) begin
            ref_sym = r;
            slice   = hist[2] ^ {{2{inv[1]}}, {2{inv[0]}}};
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = r;
        end
        @(posedge sys_clk);
        @(negedge sys_clk);
        sym_clk_en = 1'b0;
        clr_acc    = 1'b0;
        start      = 1'b0;
        if (en && sym_err8[1]) err1_pulses++;
        if (rv8) begin
            rv_cnt++;
            check_res8();
        end
        if (rv4) check_res4();
    endtask

    task automatic sym(input logic clr, input logic [1:0] inv);
        step(1'b1, clr, 1'b0, inv);
        repeat (3) step(1'b0, 1'b0, 1'b0, 2'b00);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy8), 0);
        chk({tag, "_rv"}, 32'(rv8), 0);
        chk({tag, "_sym_cnt"}, 32'(sym_cnt8), 0);
        chk({tag, "_err_cnt"}, 32'(err_cnt8), 0);
        chk({tag, "_err_sat"}, 32'(err_sat8), 0);
        chk({tag, "_sym_cor"}, 32'(sym_cor8), 0);
        chk({tag, "_sym_err"}, 32'(sym_err8), 0);
    endtask

    // mode: 1 = invert ch1 at window symbols 5 and 9, 2 = invert ch0 throughout,
    //       4 = stray clr_acc in ALIGN and unqualified clr_acc in SYNC, 8 = start during MEASURE
    task automatic run_window(input int n, input int mode, input exp_t e8, input exp_t e4, input int abort_at);
        logic [1:0] inv;
        rv_cnt      = 0;
        err1_pulses = 0;
        step(1'b0, 1'b0, 1'b1, 2'b00);
        chk("busy_rise", 32'(busy8), 1);
        for (int a = 0; a < 3; a++) sym((mode & 4) != 0 && a == 1, 2'b00);
        if ((mode & 4) != 0) step(1'b0, 1'b1, 1'b0, 2'b00);
        sym(1'b1, 2'b00);
        for (int i = 1; i <= n; i++) begin
            if (i == n) begin
                q8.push_back(e8);
                q4.push_back(e4);
            end
            inv = {((mode & 1) != 0 && (i == 5 || i == 9)), ((mode & 2) != 0)};
            step(1'b1, i == n, 1'b0, inv);
            if (i == abort_at) begin
                reset = 1'b1;
                #1;
                chk_zero("abort");
                @(posedge sys_clk);
                @(negedge sys_clk);
                reset = 1'b0;
                hist  = '{default: '0};
                repeat (8) step(1'b0, 1'b0, 1'b0, 2'b00);
                chk("abort_no_rv", 32'(rv_cnt), 0);
                chk("abort_busy", 32'(busy8), 0);
                return;
            end
            step(1'b0, 1'b0, (mode & 8) != 0 && i == 7, 2'b00);
            repeat (2) step(1'b0, 1'b0, 1'b0, 2'b00);
        end
        chk("rv_count", 32'(rv_cnt), 1);
        chk("busy_fall", 32'(busy8), 0);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        hist       = '{default: '0};
        reset      = 1'b1;
        sym_clk_en = 1'b0;
        start      = 1'b0;
        clr_acc    = 1'b0;
        ref_sym    = '0;
        slice      = '0;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        chk_zero("reset");
        reset = 1'b0;
        step(1'b0, 1'b0, 1'b0, 2'b00);

        run_window(15, 0, exp_t'{32'd15, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0},
                   exp_t'{32'd15, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0}, 0);

        run_window(15, 1, exp_t'{32'd15, 32'd0, 32'd2, 32'd0, 32'd0, 32'd5},
                   exp_t'{32'd15, 32'd0, 32'd2, 32'd0, 32'd0, 32'd5}, 0);
        chk("sym_err1_pulses", 32'(err1_pulses), 2);

        run_window(15, 0, exp_t'{32'd15, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0},
                   exp_t'{32'd15, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0}, 7);
        q8.delete();
        q4.delete();
        run_window(15, 0, exp_t'{32'd15, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0},
                   exp_t'{32'd15, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0}, 0);

        run_window(31, 2, exp_t'{32'd31, 32'd31, 32'd0, 32'd0, 32'd1, 32'd0},
                   exp_t'{32'd15, 32'd15, 32'd0, 32'd1, 32'd1, 32'd0}, 0);

        run_window(15, 4, exp_t'{32'd15, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0},
                   exp_t'{32'd15, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0}, 0);

        run_window(15, 8, exp_t'{32'd15, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0},
                   exp_t'{32'd15, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0}, 0);
        repeat (8) step(1'b0, 1'b0, 1'b0, 2'b00);
        chk("idle_busy", 32'(busy8), 0);

        chk("queues_drained", 32'(q8.size() + q4.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sym_err_meter.md
# sym_err_meter

Parametrised multi-channel symbol-error meter for the MER/BER test harness. Delays the LFSR reference symbols of each channel by a configurable pipeline depth, compares them with the slicer decisions, and counts compared and mismatched symbols over exactly one LFSR period framed by `clr_acc`. It replaces the fixed two-channel, depth-3 compare logic in the measurement top level with a single armed, self-aligning, single-shot measurement engine.

## Interface
Parameters:
- `NUM_CH`, 2, number of channels (I, Q, ...)
- `SYM_WID`, 2, bits per symbol
- `DELAY`, 3, reference delay in symbols, ≥1 (LFSR-to-slicer latency)
- `CNT_WID`, 24, width of the symbol and error counters

Ports:
- `sys_clk`  in  1  system clock; the block's only clock
- `reset`  in  1  asynchronous, active-high reset
- `sym_clk_en`  in  1  symbol strobe; all symbol-rate activity is qualified by it
- `start`  in  1  arm a measurement; sampled only in IDLE
- `clr_acc`  in  1  LFSR cycle pulse marking the window boundary; honoured only when `sym_clk_en`=1
- `ref_sym`  in  NUM_CH*SYM_WID  LFSR symbols; channel c is at [c*SYM_WID +: SYM_WID]
- `slice`  in  NUM_CH*SYM_WID  slicer decisions, same packing
- `busy`  out  1  high in every state except IDLE
- `result_valid`  out  1  one-`sys_clk` pulse when the results update
- `sym_cnt`  out  CNT_WID  latched number of symbols compared
- `err_cnt`  out  NUM_CH*CNT_WID  latched mismatch count per channel
- `err_sat`  out  NUM_CH  latched per-channel error-counter saturation flag
- `sym_cor`, `sym_err`  out  NUM_CH each  registered per-symbol match/mismatch indicators, always running

## Operation
- Per channel, a DELAY-stage shift register loads `ref_sym` on each strobe. `equal[c]` = (stage DELAY-1 == slice channel c), combinational.
- On each strobe, `sym_cor[c]` <= `equal[c]` and `sym_err[c]` <= ~`equal[c]` in all states.
- State machine:
  - IDLE: `start`=1 -> ALIGN; clear the align counter.
  - ALIGN: count DELAY strobes to flush the delay line; a `clr_acc` seen here is ignored. After the DELAY-th strobe -> SYNC.
  - SYNC: on a strobe with `clr_acc`=1 -> MEASURE; clear the working counters. That opening strobe is not counted.
  - MEASURE: on every strobe, the working `sym_cnt` increments and each working `err_cnt[c]` increments if `equal[c]`=0. The strobe carrying the closing `clr_acc` is counted. That strobe also latches the outputs (including the final increment), pulses `result_valid`, and returns to IDLE.
- Working counters saturate at 2^CNT_WID-1. The per-channel sticky saturation bit is cleared at window open and latched to `err_sat`.
- Latched outputs hold until the next window closes.
- `start` outside IDLE is ignored. `clr_acc` without `sym_clk_en` is ignored everywhere.
- Reset, at any time including mid-MEASURE:
  - state goes to IDLE;
  - the delay line, all counters, latched outputs, `sym_cor`, `sym_err`, `err_sat`, `busy` and `result_valid` go to 0;
  - no `result_valid` is produced for the aborted window.

## Timing
- `ref_sym` from strobe k is compared with `slice` at strobe k+DELAY.
- `sym_cor` and `sym_err` are visible one `sys_clk` after their strobe edge.
- `result_valid` and the latched outputs update on the `sys_clk` edge of the closing strobe. `result_valid` is high for exactly one cycle.
- `busy` rises the cycle after `start` is accepted and falls with `result_valid`.
- `sym_cnt` equals the `clr_acc` period in strobes, e.g. 2^22-1 for LFSR_22.

## Configuration
- `SYM_ERR_FIRST_IDX_EN` defined:
  - adds the output `first_err_idx`, NUM_CH*CNT_WID bits;
  - it holds the working `sym_cnt` value (1-based) of the first mismatch per channel in the window, or 0 if there was none;
  - it is latched with the other results and reset to 0.
- Undefined: the port and its logic are absent, and all other behaviour is identical.

## Structure
- Package `sym_err_pkg`: state enum typedef (IDLE, ALIGN, SYNC, MEASURE) and the saturating-increment function.
- Sub-module `sym_delay_line`: a parametrised depth×width enabled shift register with async reset, instantiated once per channel via generate.

## Test plan
Bench settings: NUM_CH=2, SYM_WID=2, DELAY=3, CNT_WID=8, `clr_acc` every 15 strobes, `sym_clk_en` every 4th `sys_clk`.
1. `slice` equals `ref_sym` delayed by 3 strobes, then `start` -> one `result_valid`, `sym_cnt`=15, `err_cnt`=0/0, `err_sat`=0/0, `busy` low afterwards.
2. Invert ch1 `slice` at window symbols 5 and 9 -> `err_cnt` ch0=0, ch1=2; `sym_err[1]` pulses twice; with the macro defined, `first_err_idx` ch1=5, ch0=0.
3. CNT_WID=4, 31-strobe window, all ch0 mismatched -> `err_cnt` ch0=15, `err_sat[0]`=1, `sym_cnt`=15.
4. Assert `reset` at window symbol 7 -> all outputs 0 in the same cycle, no `result_valid`. A fresh `start` then yields the same results as test 1.
5. `clr_acc` during ALIGN, and `clr_acc` without `sym_clk_en` in SYNC -> both ignored; the window opens on the next qualified pulse and `sym_cnt`=15.
6. Pulse `start` during MEASURE -> ignored: exactly one `result_valid`, then `busy`=0.
